// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and constants for the IF/MEM unified-RAM port arbiter.
package mem_port_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_IBUSY = 2'd1;
  localparam state_t ST_DBUSY = 2'd2;

  // Read data returned when a transaction is forced to complete by the wait timer.
  localparam logic [31:0] TIMEOUT_DATA = 32'h0000_0000;

endpackage

// File: rtl/mem_wait_timer.sv
// Clear/enable wait counter; o_tc_c flags the last allowed cycle of a RAM wait.
module mem_wait_timer #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  // Terminal count on the TIMEOUT-th enabled cycle since the last clear.
  assign o_tc_c = i_en & (r_count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported RAM between instruction fetch and load/store.
// Data accesses win; each access is a cs/ack handshake bounded by a wait timer.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  output logic              err
);

  state_t            r_state, w_state_nxt;
  logic              r_ram_cs, r_ram_we, r_if_ready, r_d_ready, r_err, r_abandon;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata, r_if_data, r_d_rdata;

  logic              w_cs_nxt, w_we_nxt, w_if_ready_nxt, w_d_ready_nxt, w_err_nxt, w_abandon_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [31:0]       w_wdata_nxt, w_if_data_nxt, w_d_rdata_nxt, w_rdata;
  logic              w_d_req, w_busy, w_tc, w_done, w_abandon, w_unused;

  assign w_d_req   = d_ren | d_wen;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_done    = w_busy & (ram_ack | w_tc);
  assign w_abandon = r_abandon | ~if_req;
  assign w_rdata   = ram_ack ? ram_rdata : TIMEOUT_DATA;
  assign w_unused  = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

  mem_wait_timer #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (~w_busy),
    .i_en   (w_busy & ~ram_ack),
    .o_tc_c (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_d_req) begin
          w_state_nxt = ST_DBUSY;
        end else if (if_req) begin
          w_state_nxt = ST_IBUSY;
        end
      end
      ST_IBUSY, ST_DBUSY: begin
        if (w_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered RAM request, read data, ready pulses and error.
  always_comb begin
    w_cs_nxt       = r_ram_cs;
    w_we_nxt       = r_ram_we;
    w_addr_nxt     = r_ram_addr;
    w_wdata_nxt    = r_ram_wdata;
    w_if_data_nxt  = r_if_data;
    w_d_rdata_nxt  = r_d_rdata;
    w_if_ready_nxt = 1'b0;
    w_d_ready_nxt  = 1'b0;
    w_err_nxt      = r_err;
    w_abandon_nxt  = r_abandon;
    unique case (r_state)
      ST_IDLE: begin
        w_abandon_nxt = 1'b0;
        if (w_d_req) begin
          w_cs_nxt    = 1'b1;
          w_we_nxt    = d_wen;
          w_addr_nxt  = d_addr[ADDR_W+1:2];
          w_wdata_nxt = d_wdata;
          if (d_ren & d_wen) w_err_nxt = 1'b1;
        end else if (if_req) begin
          w_cs_nxt   = 1'b1;
          w_we_nxt   = 1'b0;
          w_addr_nxt = if_addr[ADDR_W+1:2];
        end
      end
      ST_IBUSY: begin
        if (!if_req) w_abandon_nxt = 1'b1;
        if (w_done) begin
          w_cs_nxt      = 1'b0;
          w_we_nxt      = 1'b0;
          w_abandon_nxt = 1'b0;
          if (!ram_ack) w_err_nxt = 1'b1;
          if (!w_abandon) begin
            w_if_data_nxt  = w_rdata;
            w_if_ready_nxt = 1'b1;
          end
        end
      end
      ST_DBUSY: begin
        if (w_done) begin
          w_cs_nxt      = 1'b0;
          w_we_nxt      = 1'b0;
          w_d_ready_nxt = 1'b1;
          if (!ram_ack) w_err_nxt = 1'b1;
          if (!r_ram_we) w_d_rdata_nxt = w_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_cs    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_if_data   <= '0;
      r_d_rdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_err       <= 1'b0;
      r_abandon   <= 1'b0;
    end else begin
      r_ram_cs    <= w_cs_nxt;
      r_ram_we    <= w_we_nxt;
      r_ram_addr  <= w_addr_nxt;
      r_ram_wdata <= w_wdata_nxt;
      r_if_data   <= w_if_data_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_if_ready  <= w_if_ready_nxt;
      r_d_ready   <= w_d_ready_nxt;
      r_err       <= w_err_nxt;
      r_abandon   <= w_abandon_nxt;
    end
  end

  assign ram_cs    = r_ram_cs;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign if_data   = r_if_data;
  assign d_rdata   = r_d_rdata;
  assign if_ready  = r_if_ready;
  assign d_ready   = r_d_ready;
  assign err       = r_err;

  // IF also holds while data owns or is about to own the RAM.
  assign stall_mem = w_d_req & ~r_d_ready;
  assign stall_if  = (if_req & ~r_if_ready) | (r_state == ST_DBUSY) |
                     ((r_state == ST_IDLE) & w_d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model, directed scenarios, random traffic.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned TO_W    = 8;

  logic clk = 1'b0;
  logic rst, if_req, if_ready, d_ren, d_wen, d_ready, stall_if, stall_mem;
  logic ram_cs, ram_we, ram_ack, err;
  logic [31:0] if_addr, if_data, d_addr, d_wdata, d_rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .err(err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: at most one outstanding RAM transaction plus the visible results.
  bit                m_on = 0;
  bit                m_have, m_isd, m_we, m_aband, m_err, m_ifr, m_dr;
  int                m_cyc;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata, m_ifd, m_drd;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Predicts the effect of the coming clock edge from the inputs now applied.
  task automatic model_step();
    logic [31:0] rd;
    m_on = 1;
    if (rst) begin
      m_have = 0; m_cyc = 0; m_aband = 0; m_err = 0;
      m_ifr = 0; m_dr = 0; m_ifd = '0; m_drd = '0;
      return;
    end
    m_ifr = 0;
    m_dr  = 0;
    if (m_have) begin
      m_cyc++;
      if (!m_isd && !if_req) m_aband = 1;
      if (ram_ack || m_cyc == int'(TIMEOUT)) begin
        rd = ram_ack ? ram_rdata : 32'h0;
        if (!ram_ack) m_err = 1;
        if (m_isd) begin
          m_dr = 1;
          if (!m_we) m_drd = rd;
        end else if (!m_aband) begin
          m_ifr = 1;
          m_ifd = rd;
        end
        m_have = 0;
      end
    end else if (d_ren || d_wen) begin
      m_have = 1; m_isd = 1; m_we = d_wen; m_cyc = 0;
      m_addr = d_addr[ADDR_W+1:2]; m_wdata = d_wdata;
      if (d_ren && d_wen) m_err = 1;
    end else if (if_req) begin
      m_have = 1; m_isd = 0; m_we = 0; m_cyc = 0; m_aband = 0;
      m_addr = if_addr[ADDR_W+1:2];
    end
  endtask

  always @(negedge clk) begin
    if (m_on) begin
      chk("ram_cs", 32'(ram_cs), 32'(m_have));
      if (m_have) begin
        chk("ram_we", 32'(ram_we), 32'(m_we));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        if (m_we) chk("ram_wdata", ram_wdata, m_wdata);
      end
      chk("if_ready", 32'(if_ready), 32'(m_ifr));
      chk("d_ready", 32'(d_ready), 32'(m_dr));
      chk("if_data", if_data, m_ifd);
      chk("d_rdata", d_rdata, m_drd);
      chk("err", 32'(err), 32'(m_err));
      chk("stall_mem", 32'(stall_mem), 32'((d_ren || d_wen) && !m_dr));
      chk("stall_if", 32'(stall_if),
          32'((if_req && !m_ifr) || (m_have && m_isd) || (!m_have && (d_ren || d_wen))));
    end
  end

  task automatic go();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, " ram_cs"}, 32'(ram_cs), 32'd0);
    chk({tag, " ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, " ram_wdata"}, ram_wdata, 32'd0);
    chk({tag, " if_data"}, if_data, 32'd0);
    chk({tag, " d_rdata"}, d_rdata, 32'd0);
    chk({tag, " if_ready"}, 32'(if_ready), 32'd0);
    chk({tag, " d_ready"}, 32'(d_ready), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int ncs;
    int k;
    bit d_act;
    rst = 1; if_req = 0; if_addr = '0; d_ren = 0; d_wen = 0; d_addr = '0; d_wdata = '0;
    ram_rdata = '0; ram_ack = 0;
    go();
    go();
    check_reset_values("reset");
    rst = 0;

    // Fetch only, minimum latency.
    if_req = 1; if_addr = 32'h0000_0010;
    go();
    chk("t1 cs", 32'(ram_cs), 32'd1);
    chk("t1 addr", 32'(ram_addr), 32'd4);
    chk("t1 we", 32'(ram_we), 32'd0);
    go();
    ram_ack = 1; ram_rdata = 32'h2008_0005;
    go();
    chk("t1 if_ready", 32'(if_ready), 32'd1);
    chk("t1 if_data", if_data, 32'h2008_0005);
    chk("t1 stall_if", 32'(stall_if), 32'd0);
    if_req = 0; ram_ack = 0;
    go();
    chk("t1 pulse", 32'(if_ready), 32'd0);

    // Simultaneous requests: data first, bubble, then the fetch.
    d_ren = 1; d_addr = 32'h20; if_req = 1; if_addr = 32'h8;
    go();
    chk("t2 d addr", 32'(ram_addr), 32'd8);
    chk("t2 stall_if", 32'(stall_if), 32'd1);
    go();
    ram_ack = 1; ram_rdata = 32'hA5A5_0001;
    go();
    chk("t2 d_ready", 32'(d_ready), 32'd1);
    chk("t2 if_ready", 32'(if_ready), 32'd0);
    chk("t2 bubble", 32'(ram_cs), 32'd0);
    chk("t2 d_rdata", d_rdata, 32'hA5A5_0001);
    d_ren = 0; ram_ack = 0;
    go();
    chk("t2 i cs", 32'(ram_cs), 32'd1);
    chk("t2 i addr", 32'(ram_addr), 32'd2);
    go();
    ram_ack = 1; ram_rdata = 32'h1111_2222;
    go();
    chk("t2 if_ready", 32'(if_ready), 32'd1);
    chk("t2 if_data", if_data, 32'h1111_2222);
    if_req = 0; ram_ack = 0;
    go();

    // Store with a three-cycle RAM wait.
    d_wen = 1; d_addr = 32'h44; d_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      go();
      chk("t3 we", 32'(ram_we), 32'd1);
      chk("t3 addr", 32'(ram_addr), 32'h11);
      chk("t3 wdata", ram_wdata, 32'hDEAD_BEEF);
    end
    ram_ack = 1; ram_rdata = 32'hFFFF_FFFF;
    go();
    chk("t3 d_ready", 32'(d_ready), 32'd1);
    chk("t3 d_rdata", d_rdata, 32'hA5A5_0001);
    d_wen = 0; ram_ack = 0;
    go();
    chk("t3 pulse", 32'(d_ready), 32'd0);

    // Fetch flushed while waiting: RAM completes, nothing reported.
    if_req = 1; if_addr = 32'h100;
    go();
    if_req = 0;
    go();
    ram_ack = 1; ram_rdata = 32'h1234_5678;
    go();
    chk("t4 if_ready", 32'(if_ready), 32'd0);
    chk("t4 if_data", if_data, 32'h1111_2222);
    ram_ack = 0;
    go();
    chk("t4 idle cs", 32'(ram_cs), 32'd0);

    // Timeout, then err stays set across a good fetch.
    d_ren = 1; d_addr = 32'h30;
    go();
    ncs = 0;
    for (int i = 0; i < 10 && !d_ready; i++) begin
      if (ram_cs) ncs++;
      go();
    end
    chk("t5 busy cycles", 32'(ncs), 32'd4);
    chk("t5 d_ready", 32'(d_ready), 32'd1);
    chk("t5 d_rdata", d_rdata, 32'd0);
    chk("t5 err", 32'(err), 32'd1);
    d_ren = 0;
    if_req = 1; if_addr = 32'h4;
    go();
    go();
    ram_ack = 1; ram_rdata = 32'h55;
    go();
    chk("t5 good fetch", if_data, 32'h55);
    chk("t5 err sticky", 32'(err), 32'd1);
    if_req = 0; ram_ack = 0;
    go();

    // Reset in the middle of a data access, then a late ack.
    d_ren = 1; d_addr = 32'h8;
    go();
    go();
    rst = 1; d_ren = 0;
    go();
    rst = 0; ram_ack = 1; ram_rdata = 32'hCAFE_0000;
    go();
    check_reset_values("t6");
    ram_ack = 0;
    go();
    chk("t6 d_ready", 32'(d_ready), 32'd0);
    chk("t6 if_ready", 32'(if_ready), 32'd0);

    // Random traffic against the model.
    d_act = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (d_act && (m_dr || $urandom_range(0, 39) == 0)) d_act = 0;
      if (!d_act && $urandom_range(0, 5) == 0) begin
        d_act   = 1;
        k       = int'($urandom_range(0, 19));
        d_wen   = (k < 8);
        d_ren   = (k >= 8) || (k == 0);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      if (!d_act) begin
        d_ren = 0;
        d_wen = 0;
      end
      if (if_req && m_ifr) begin
        if_addr = $urandom;
        if_req  = ($urandom_range(0, 3) != 0);
      end else if (if_req && $urandom_range(0, 19) == 0) begin
        if_req = 0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1;
        if_addr = $urandom;
      end
      ram_rdata = $urandom;
      ram_ack   = m_have ? (m_cyc >= 1 && $urandom_range(0, 1) == 1)
                         : ($urandom_range(0, 15) == 0);
      go();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipelined MIPS CPU.
- Sequences each RAM transaction with a ready/ack handshake.
- Generates the stall signals the pipeline controller uses to deassert if_en / mem_en.
- Data accesses (MEM, the older instruction) have priority over fetches.

Parameters:
ADDR_W, 12, RAM word-address width; ram_addr = byte_addr[ADDR_W+1:2]
TIMEOUT, 255, max cycles to wait for ram_ack before forced completion
TO_W, 8, timeout counter width (must satisfy 2^TO_W > TIMEOUT)

Ports:
clk  in  1  main clock
rst  in  1  synchronous active-high reset
if_req  in  1  instruction read request (inst_ren)
if_addr  in  32  instruction byte address
if_data  out  32  fetched instruction, valid when if_ready
if_ready  out  1  one-cycle pulse: fetch complete
d_ren  in  1  data read request
d_wen  in  1  data write request
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_rdata  out  32  load data, valid when d_ready
d_ready  out  1  one-cycle pulse: data access complete
stall_if  out  1  hold IF stage
stall_mem  out  1  freeze MEM and all earlier stages
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid with ram_ack
ram_ack  in  1  RAM transaction complete (any cycle ≥1 after cs)
err  out  1  sticky error flag

Behaviour:
- States: IDLE, I_BUSY, D_BUSY.
- Reset (including mid-transaction): state=IDLE; ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0; if_data=0, d_rdata=0; if_ready=0, d_ready=0; err=0; timeout counter=0. An ack arriving in the cycle after reset is ignored.
- IDLE:
  - If d_ren|d_wen: latch d_addr/d_wdata, assert ram_cs, set ram_we=d_wen, go D_BUSY.
  - Else if if_req: latch if_addr, assert ram_cs, ram_we=0, go I_BUSY.
  - Else stay.
  - Arbitration is sampled at the clock edge; data wins simultaneous requests.
- BUSY:
  - ram_cs/ram_we/ram_addr/ram_wdata are registered and held stable until ack.
  - Counter increments each cycle.
- On ram_ack in BUSY:
  - Capture ram_rdata into if_data (I_BUSY) or d_rdata (D_BUSY).
  - Pulse the matching ready for exactly one cycle on the next edge.
  - Drop ram_cs and return to IDLE. This gives one bubble cycle between transactions.
  - Minimum latency: request at edge N → ram_cs high after N → ack at N+1 → ready high after N+2.
- Write: d_rdata is unchanged; d_ready still pulses.
- d_ren & d_wen both high: treated as a write; err set.
- Fetch abandoned (if_req low in any I_BUSY cycle, e.g. branch flush):
  - Set an internal abandon flag.
  - The RAM transaction still completes on ack.
  - if_data is not updated and if_ready does not pulse.
  - The flag clears on return to IDLE.
- Data request dropped mid-transaction: the transaction completes and d_ready pulses anyway; err is not set.
- Timeout: counter reaches TIMEOUT without ack → set err, complete as if acked with read data 32'h0000_0000, ready pulses (honouring abandon), return to IDLE. This prevents pipeline deadlock.
- stall_mem = (d_ren|d_wen) & ~d_ready (combinational).
- stall_if = if_req & ~if_ready (combinational). It is also high whenever state=D_BUSY or a data request is pending in IDLE.
- Address bits [1:0] are ignored. Any nonzero upper bits above ADDR_W+1 are ignored (no error).
- err clears only on rst.

Decomposition:
- Shared package holds:
  - State encoding localparams ST_IDLE=2'd0, ST_IBUSY=2'd1, ST_DBUSY=2'd2.
  - Constant TIMEOUT_DATA=32'h0.
- One natural sub-module, mem_wait_timer: a clear/enable counter with a terminal-count output, parameterised by TO_W and TIMEOUT.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x0000_0010, ack one cycle after cs with rdata=0x2008_0005 → ram_addr=4, ram_we=0; if_ready pulses at N+2 with if_data=0x2008_0005; stall_if low that cycle.
2. Simultaneous: d_ren=1, d_addr=0x20, if_req=1, if_addr=0x8 → data served first (ram_addr=8); stall_if high throughout; fetch ram_addr=2 issues after the bubble; d_ready precedes if_ready.
3. Store: d_wen=1, d_addr=0x44, d_wdata=0xDEAD_BEEF, ack after 3 cycles → ram_we=1, ram_addr=0x11, ram_wdata held 3 cycles; d_ready one pulse; d_rdata unchanged.
4. Flush: if_req drops in I_BUSY, then ack with rdata=0x1234_5678 → no if_ready pulse; if_data keeps old value; state returns to IDLE.
5. Timeout: TIMEOUT=4, d_ren=1, ack never asserted → d_ready pulses after 4 busy cycles with d_rdata=0; err=1 and stays 1 across subsequent good transactions until rst.
6. Reset mid-D_BUSY: assert rst for one cycle, then ack → all outputs at reset values; no ready pulses; err=0.
